controle_fila: RTL and testbench



---
 rtl/fila_pkg.sv | 9 +
 rtl/detecta_borda.sv | 21 ++
 rtl/controle_fila.sv | 117 +++++++++++
 tb/tb_controle_fila.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fila_pkg.sv
// Shared types and sizing for the queue controller and the queue itself.
package fila_pkg;

  localparam int unsigned FILA_DEPTH   = 8;
  localparam int unsigned FILA_COUNT_W = 4;

  typedef enum logic [1:0] {IDLE, ENQ, ACK, DEQ} ctrl_state_t;

endpackage

// File: rtl/detecta_borda.sv
// 1-bit rising-edge detector: pulses for the cycle in which the input goes 0 -> 1.
module detecta_borda (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/controle_fila.sv
// Handshake sequencer between deserializer and fila: arbitrates enqueue/dequeue,
// tracks occupancy and acknowledges bytes only once they have been committed.
module controle_fila
  import fila_pkg::*;
#(
  parameter int unsigned DEPTH   = FILA_DEPTH,
  parameter int unsigned COUNT_W = FILA_COUNT_W
) (
  input  logic               clk_10KHz,
  input  logic               reset,
  input  logic               data_ready_in,
  input  logic               dequeue_in,
  output logic               enqueue_out,
  output logic               dequeue_out,
  output logic               ack_out,
  output logic [COUNT_W-1:0] count_out,
  output logic               full_out,
  output logic               empty_out,
  output logic               underflow_out
);

  localparam logic [COUNT_W-1:0] DepthC = COUNT_W'(DEPTH);

  ctrl_state_t        state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               deq_pend_q, deq_pend_d;
  logic               last_deq_q, last_deq_d;
  logic               underflow_q, underflow_d;
  logic               enq_q, deq_q, ack_q;
  logic               full_q, empty_q;
  logic               deq_rise;
  logic               enq_ok, deq_ok;

  detecta_borda u_borda_deq (
    .clk_i   (clk_10KHz),
    .reset_i (reset),
    .sig_i   (dequeue_in),
    .rise_o  (deq_rise)
  );

  assign enq_ok = data_ready_in & ~full_q;
  assign deq_ok = deq_pend_q & ~empty_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    deq_pend_d  = deq_pend_q;
    last_deq_d  = last_deq_q;
    underflow_d = underflow_q;
    case (state_q)
      IDLE: begin
        // Round-robin on a tie; every grant updates the history.
        if (enq_ok && (!deq_ok || last_deq_q)) begin
          state_d    = ENQ;
          last_deq_d = 1'b0;
        end else if (deq_ok) begin
          state_d    = DEQ;
          last_deq_d = 1'b1;
          deq_pend_d = 1'b0;
        end else if (deq_pend_q && empty_q && !data_ready_in) begin
          deq_pend_d  = 1'b0;
          underflow_d = 1'b1;
        end
      end
      ENQ: begin
        state_d = ACK;
        count_d = count_q + 1'b1;
      end
      ACK: begin
        // Hold ack until the deserializer drops its request, so one byte enqueues once.
        if (!data_ready_in) state_d = IDLE;
      end
      DEQ: begin
        state_d = IDLE;
        count_d = count_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // A new edge wins over the clear done on DEQ entry.
    if (deq_rise) deq_pend_d = 1'b1;
  end

  always_ff @(posedge clk_10KHz) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      deq_pend_q  <= 1'b0;
      last_deq_q  <= 1'b1;
      underflow_q <= 1'b0;
      enq_q       <= 1'b0;
      deq_q       <= 1'b0;
      ack_q       <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      deq_pend_q  <= deq_pend_d;
      last_deq_q  <= last_deq_d;
      underflow_q <= underflow_d;
      enq_q       <= (state_d == ENQ);
      deq_q       <= (state_d == DEQ);
      ack_q       <= (state_d == ACK);
      full_q      <= (count_d == DepthC);
      empty_q     <= (count_d == '0);
    end
  end

  assign enqueue_out   = enq_q;
  assign dequeue_out   = deq_q;
  assign ack_out       = ack_q;
  assign count_out     = count_q;
  assign full_out      = full_q;
  assign empty_out     = empty_q;
  assign underflow_out = underflow_q;

endmodule

// File: tb/tb_controle_fila.sv
// Bench for controle_fila: directed scenarios with literal expectations plus a
// randomized deserializer/user against a queue-based reference model.
module tb_controle_fila;

  localparam int DEPTH = 8;

  logic       clk_10KHz = 1'b0;
  logic       reset = 1'b1;
  logic       data_ready_in = 1'b0;
  logic       dequeue_in = 1'b0;
  logic       enqueue_out, dequeue_out, ack_out;
  logic [3:0] count_out;
  logic       full_out, empty_out, underflow_out;

  int checks = 0;
  int errors = 0;

  controle_fila #(.DEPTH(8), .COUNT_W(4)) dut (
    .clk_10KHz     (clk_10KHz),
    .reset         (reset),
    .data_ready_in (data_ready_in),
    .dequeue_in    (dequeue_in),
    .enqueue_out   (enqueue_out),
    .dequeue_out   (dequeue_out),
    .ack_out       (ack_out),
    .count_out     (count_out),
    .full_out      (full_out),
    .empty_out     (empty_out),
    .underflow_out (underflow_out)
  );

  always #50 clk_10KHz = ~clk_10KHz;

  // Reference model: the fila is a queue of byte serial numbers; the controller
  // is described by what it is busy doing this cycle.
  localparam int MFree = 0, MEnqPulse = 1, MAcking = 2, MDeqPulse = 3;
  int  m_q[$];
  int  m_doing;
  int  m_serial;
  bit  m_pend, m_under, m_prev, m_last_was_enq, started = 0;

  always @(posedge clk_10KHz) begin
    bit rise, can_enq, can_deq;
    if (reset) begin
      m_q.delete();
      m_doing = MFree;
      m_pend = 0; m_under = 0; m_prev = 0; m_last_was_enq = 0;
      started = 1;
    end else if (started) begin
      rise = dequeue_in && !m_prev;
      m_prev = dequeue_in;
      case (m_doing)
        MEnqPulse: begin m_q.push_back(m_serial); m_serial++; m_doing = MAcking; end
        MAcking:   if (!data_ready_in) m_doing = MFree;
        MDeqPulse: begin void'(m_q.pop_front()); m_doing = MFree; end
        default: begin
          can_enq = data_ready_in && (m_q.size() < DEPTH);
          can_deq = m_pend && (m_q.size() > 0);
          if (can_enq && (!can_deq || !m_last_was_enq)) begin
            m_doing = MEnqPulse; m_last_was_enq = 1;
          end else if (can_deq) begin
            m_doing = MDeqPulse; m_last_was_enq = 0; m_pend = 0;
          end else if (m_pend && m_q.size() == 0 && !data_ready_in) begin
            m_pend = 0; m_under = 1;
          end
        end
      endcase
      if (rise) m_pend = 1;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk_10KHz) begin
    logic [10:0] act, expv;
    if (started) begin
      act  = {enqueue_out, dequeue_out, ack_out, count_out, full_out, empty_out, underflow_out};
      expv = {m_doing == MEnqPulse, m_doing == MDeqPulse, m_doing == MAcking,
              4'(m_q.size()), m_q.size() == DEPTH, m_q.size() == 0, m_under};
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL model_cmp t=%0t got enq,deq,ack,cnt,full,empty,unf=%b expected %b",
                 $time, act, expv);
      end
      assert (count_out <= 4'(DEPTH)) else begin
        errors++;
        $display("FAIL count_bound got %0d expected <= %0d", count_out, DEPTH);
      end
    end
  end

  task automatic tick();
    @(negedge clk_10KHz);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic wait_ack(input bit lvl);
    int n = 0;
    while (ack_out !== lvl && n < 20) begin tick(); n++; end
    if (ack_out !== lvl) chk("ack_timeout", int'(ack_out), int'(lvl));
  endtask

  task automatic do_reset();
    reset = 1; data_ready_in = 0; dequeue_in = 0;
    tick(); tick();
    reset = 0;
  endtask

  task automatic do_enq();
    data_ready_in = 1;
    wait_ack(1);
    data_ready_in = 0;
    wait_ack(0);
  endtask

  task automatic do_deq();
    int n = 0;
    dequeue_in = 1; tick(); dequeue_in = 0;
    while (dequeue_out !== 1'b1 && n < 20) begin tick(); n++; end
    if (dequeue_out !== 1'b1) chk("deq_timeout", int'(dequeue_out), 1);
    tick();
  endtask

  initial begin
    int n;
    do_reset();
    chk("rst_count", count_out, 0);
    chk("rst_empty", empty_out, 1);
    chk("rst_full", full_out, 0);
    chk("rst_ack", ack_out, 0);

    // Dequeue while empty
    dequeue_in = 1;
    tick(); chk("unf_c1", underflow_out, 0); chk("unf_deq_c1", dequeue_out, 0);
    tick(); chk("unf_c2", underflow_out, 1); chk("unf_deq_c2", dequeue_out, 0);
    dequeue_in = 0;
    tick(); chk("unf_count", count_out, 0);

    // Single enqueue with held data_ready
    data_ready_in = 1;
    tick(); chk("enq_c1", enqueue_out, 1); chk("ack_c1", ack_out, 0);
    tick(); chk("enq_c2", enqueue_out, 0); chk("ack_c2", ack_out, 1); chk("cnt_c2", count_out, 1);
    tick(); tick(); chk("ack_c4", ack_out, 1);
    data_ready_in = 0;
    tick(); chk("ack_c5", ack_out, 0); chk("enq_c5", enqueue_out, 0);
    tick(); chk("enq_c6", enqueue_out, 0); chk("cnt_c6", count_out, 1);
    chk("unf_sticky", underflow_out, 1);

    // Fill to full, then a blocked 9th byte
    do_reset();
    repeat (8) do_enq();
    chk("full_cnt", count_out, 8); chk("full_flag", full_out, 1);
    data_ready_in = 1;
    repeat (4) begin tick(); chk("full_noenq", enqueue_out, 0); chk("full_noack", ack_out, 0); end
    dequeue_in = 1;
    tick(); chk("fd_c1", dequeue_out, 0);
    tick(); chk("fd_c2", dequeue_out, 1); dequeue_in = 0;
    tick(); chk("fd_cnt7", count_out, 7); chk("fd_noenq", enqueue_out, 0);
    tick(); chk("fd_enq9", enqueue_out, 1);
    tick(); chk("fd_ack9", ack_out, 1); chk("fd_cnt8", count_out, 8); chk("fd_full", full_out, 1);
    data_ready_in = 0; wait_ack(0);

    // Ties: count=3 reached with a dequeue as the last grant
    do_reset();
    repeat (4) do_enq();
    do_deq();
    chk("tie_cnt3", count_out, 3);
    for (int k = 0; k < 2; k++) begin
      dequeue_in = 1;
      tick(); data_ready_in = 1; dequeue_in = 0;
      tick(); chk("tie_enq_first", enqueue_out, 1); chk("tie_nodeq", dequeue_out, 0);
      tick(); chk("tie_ack", ack_out, 1); chk("tie_cnt4", count_out, 4); data_ready_in = 0;
      tick(); chk("tie_ack_off", ack_out, 0);
      tick(); chk("tie_deq", dequeue_out, 1);
      tick(); chk("tie_cnt_back", count_out, 3);
    end

    // Held dequeue level gives exactly one dequeue
    do_reset();
    repeat (5) do_enq();
    dequeue_in = 1; n = 0;
    repeat (10) begin tick(); n += int'(dequeue_out); end
    dequeue_in = 0;
    repeat (4) begin tick(); n += int'(dequeue_out); end
    chk("held_deq_pulses", n, 1); chk("held_cnt", count_out, 4);

    // Reset during ACK
    do_reset();
    repeat (2) do_enq();
    data_ready_in = 1; wait_ack(1);
    reset = 1;
    tick(); chk("rack_ack", ack_out, 0); chk("rack_cnt", count_out, 0);
    chk("rack_empty", empty_out, 1); chk("rack_enq", enqueue_out, 0);
    reset = 0; data_ready_in = 0;
    tick(); chk("rack_noenq", enqueue_out, 0);
    tick(); chk("rack_noenq2", enqueue_out, 0);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (reset) reset = 0;
      else if ($urandom_range(0, 599) == 0) reset = 1;
      if (!data_ready_in) begin
        if ($urandom_range(0, 2) == 0) data_ready_in = 1;
      end else if (ack_out && $urandom_range(0, 1) == 0) begin
        data_ready_in = 0;
      end
      if ($urandom_range(0, 3) == 0) dequeue_in = ~dequeue_in;
    end
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
